// File: rtl/pkt_pkg.sv
// Shared types and default sizing for the packet ingress buffer.
package pkt_pkg;
  localparam int PKT_W      = 24;
  localparam int NUM_SLOTS  = 6;
  localparam int FIFO_DEPTH = 4;
  localparam int DEST_W     = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } state_t;

  // One queued ingress packet: target slot index plus payload.
  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [PKT_W-1:0]  data;
  } entry_t;
endpackage

// File: rtl/packet_ingress_buffer_if.sv
// Upstream valid/ready packet handshake into the ingress buffer.
interface packet_ingress_buffer_if #(
  parameter int PKT_W = pkt_pkg::PKT_W
);
  logic                       in_valid;
  logic                       in_ready;
  logic [pkt_pkg::DEST_W-1:0] in_dest;
  logic [PKT_W-1:0]           in_data;

  modport master (output in_valid, in_dest, in_data, input in_ready);
  modport slave  (input in_valid, in_dest, in_data, output in_ready);
endinterface

// File: rtl/pkt_fifo.sv
// Small power-of-two FIFO with occupancy count and synchronous flush.
module pkt_fifo #(
  parameter int W     = 27,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wr_data,
  output logic [W-1:0]     rd_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  // Guard against overflow/underflow so the pointers can never slip.
  assign do_push = push && !flush && !full;
  assign do_pop  = pop && !flush && !empty;

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q];
  assign full    = (level_q == DEPTH_L);
  assign empty   = (level_q == '0);
  assign level   = level_q;
endmodule

// File: rtl/packet_ingress_buffer.sv
// Queues incoming packets and commits each one into its destination slot.
module packet_ingress_buffer #(
  parameter int NUM_SLOTS  = pkt_pkg::NUM_SLOTS,
  parameter int PKT_W      = pkt_pkg::PKT_W,
  parameter int FIFO_DEPTH = pkt_pkg::FIFO_DEPTH
) (
  input  logic                          clock,
  input  logic                          clear_n,
  input  logic                          flush,
  packet_ingress_buffer_if.slave        ing,
  output logic [PKT_W-1:0]              packet_out [NUM_SLOTS-1:0],
  output logic [NUM_SLOTS-1:0]          slot_valid,
  output logic [7:0]                    drop_count,
  output logic [2:0]                    fifo_level
);
  import pkt_pkg::*;

  state_t     state_q, state_d;
  entry_t     hold_q, hold_d;
  entry_t     fifo_wr, fifo_rd;
  logic       fifo_full, fifo_empty;
  logic       push, pop, commit, dest_ok;
  logic [7:0] drop_q;

  // Ready depends only on occupancy, flush and reset, never on in_valid.
  assign ing.in_ready = clear_n && !fifo_full && !flush;
  assign push         = ing.in_valid && ing.in_ready;
  assign fifo_wr.dest = ing.in_dest;
  assign fifo_wr.data = ing.in_data;

  // Any non-empty cycle pops the head into the holding register.
  assign pop     = !fifo_empty && !flush;
  assign commit  = (state_q == COMMIT) && !flush;
  assign dest_ok = 32'(hold_q.dest) < NUM_SLOTS;

  pkt_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .clear_n (clear_n),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .wr_data (fifo_wr),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // FSM next state: capture the head on every pop, flush returns to IDLE.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = COMMIT;
          hold_d  = fifo_rd;
        end
      end
      COMMIT: begin
        if (pop) begin
          state_d = COMMIT;
          hold_d  = fifo_rd;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      hold_d  = '0;
    end
  end

  // FSM state and holding register.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Drop counter for out-of-range destinations, saturating at 255.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      drop_q <= '0;
    end else if (flush) begin
      drop_q <= '0;
    end else if (commit && !dest_ok && drop_q != 8'hFF) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign drop_count = drop_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      logic [PKT_W-1:0] data_q;
      logic             valid_q;
      logic             wr_en;

      assign wr_en = commit && (hold_q.dest == DEST_W'(gi));

      // One output slot: last commit to this index wins.
      always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else if (flush) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else if (wr_en) begin
          data_q  <= hold_q.data;
          valid_q <= 1'b1;
        end
      end

      assign packet_out[gi] = data_q;
      assign slot_valid[gi] = valid_q;
    end
  endgenerate
endmodule
